// File: rtl/wb_regfile.sv
// Writeback stage plus the 32x32 architectural register file: result select,
// single write port, two combinational read ports with same-cycle bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Regfile_weW,
  input  logic              memToRegW,
  input  logic [DATA_W-1:0] aluOutW,
  input  logic [DATA_W-1:0] readDataW,
  input  logic [ADDR_W-1:0] writeRegAddrW,
  output logic [DATA_W-1:0] resultW,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [31:0]       wbCount,
  input  logic              clr_count
);

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [31:0]       wb_count_q;
  logic [31:0]       wb_count_d;
  logic              we_eff_s;

  // Writeback value select, independent of the write enable
  always_comb begin
    resultW = aluOutW;
    if (memToRegW) begin
      resultW = readDataW;
    end else begin
      resultW = aluOutW;
    end
  end

  // r0 is never a write target; a low enable masks any X on the address
  always_comb begin
    we_eff_s = Regfile_weW && (writeRegAddrW != ZERO_A);
  end

  // Register storage; r0 is held at zero and only ever read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= ZERO_D;
      end
    end else if (we_eff_s) begin
      regs_q[writeRegAddrW] <= resultW;
    end
  end

  // Read port 1 with write-through bypass for the WB-to-ID hazard
  always_comb begin
    rdata1 = ZERO_D;
    if (raddr1 == ZERO_A) begin
      rdata1 = ZERO_D;
    end else if (we_eff_s && (writeRegAddrW == raddr1)) begin
      rdata1 = resultW;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  // Read port 2, same rules as port 1
  always_comb begin
    rdata2 = ZERO_D;
    if (raddr2 == ZERO_A) begin
      rdata2 = ZERO_D;
    end else if (we_eff_s && (writeRegAddrW == raddr2)) begin
      rdata2 = resultW;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

  // Retired-writeback count; clear wins over a same-cycle increment
  always_comb begin
    wb_count_d = wb_count_q;
    if (clr_count) begin
      wb_count_d = 32'd0;
    end else if (we_eff_s) begin
      wb_count_d = wb_count_q + 32'd1;
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // Counter register, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count_q <= 32'd0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wbCount = wb_count_q;

  wb_regfile_chk #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_chk (
    .rst       (rst),
    .memToRegW (memToRegW),
    .aluOutW   (aluOutW),
    .readDataW (readDataW),
    .resultW   (resultW),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .raddr2    (raddr2),
    .rdata2    (rdata2)
  );

endmodule

// Structural invariants of the writeback/regfile outputs.
module wb_regfile_chk #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              rst,
  input logic              memToRegW,
  input logic [DATA_W-1:0] aluOutW,
  input logic [DATA_W-1:0] readDataW,
  input logic [DATA_W-1:0] resultW,
  input logic [ADDR_W-1:0] raddr1,
  input logic [DATA_W-1:0] rdata1,
  input logic [ADDR_W-1:0] raddr2,
  input logic [DATA_W-1:0] rdata2
);

  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  // r0 always reads zero on both ports
  always_comb begin
    a_r0_port1: assert ((rst !== 1'b0) || (raddr1 !== ZERO_A) || (rdata1 === ZERO_D))
      else $error("r0 read on port 1 returned %h", rdata1);
    a_r0_port2: assert ((rst !== 1'b0) || (raddr2 !== ZERO_A) || (rdata2 === ZERO_D))
      else $error("r0 read on port 2 returned %h", rdata2);
  end

  // Load select must pass load data through unchanged
  always_comb begin
    a_result_sel: assert ((memToRegW !== 1'b1) || (resultW === readDataW))
      else $error("resultW %h does not match load data %h", resultW, readDataW);
    a_result_alu: assert ((memToRegW !== 1'b0) || (resultW === aluOutW))
      else $error("resultW %h does not match ALU result %h", resultW, aluOutW);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against an array-based model.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        Regfile_weW;
  logic        memToRegW;
  logic [31:0] aluOutW;
  logic [31:0] readDataW;
  logic [4:0]  writeRegAddrW;
  logic [31:0] resultW;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] wbCount;
  logic        clr_count;

  int n_assert;
  int n_fail;

  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .Regfile_weW   (Regfile_weW),
    .memToRegW     (memToRegW),
    .aluOutW       (aluOutW),
    .readDataW     (readDataW),
    .writeRegAddrW (writeRegAddrW),
    .resultW       (resultW),
    .raddr1        (raddr1),
    .rdata1        (rdata1),
    .raddr2        (raddr2),
    .rdata2        (rdata2),
    .wbCount       (wbCount),
    .clr_count     (clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ra, input logic we,
                                           input logic [4:0] wa, input logic [31:0] res);
    if (ra == 5'd0) return 32'd0;
    if (we && (wa != 5'd0) && (wa == ra)) return res;
    return mregs[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0;
  endtask

  // One pipeline cycle: called just after a falling edge, returns after the next one.
  task automatic step(input logic we, input logic m2r, input logic [31:0] alu,
                      input logic [31:0] rd, input logic [4:0] wa,
                      input logic [4:0] r1, input logic [4:0] r2, input logic clr);
    logic [31:0] res;
    Regfile_weW = we; memToRegW = m2r; aluOutW = alu; readDataW = rd;
    writeRegAddrW = wa; raddr1 = r1; raddr2 = r2; clr_count = clr;
    res = m2r ? rd : alu;
    #1;
    chk("resultW", resultW, res);
    chk("rdata1", rdata1, exp_read(r1, we, wa, res));
    chk("rdata2", rdata2, exp_read(r2, we, wa, res));
    @(posedge clk);
    if (we && wa != 5'd0) begin
      mregs[wa] = res;
      mcnt = mcnt + 32'd1;
    end
    if (clr) mcnt = 32'd0;
    @(negedge clk);
    #1;
    chk("wbCount", wbCount, mcnt);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; Regfile_weW = 1'b0; memToRegW = 1'b0; aluOutW = 32'd0;
    readDataW = 32'd0; writeRegAddrW = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
    clr_count = 1'b0;
    model_reset();

    // Reset state on every index
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      chk("reset_rdata1", rdata1, 32'd0);
      chk("reset_rdata2", rdata2, 32'd0);
    end
    chk("reset_wbCount", wbCount, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Asynchronous reset between edges wipes r5
    step(1'b1, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 5'd0, 5'd0, 1'b0);
    Regfile_weW = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    chk("r5_written", rdata1, 32'h0000_1234);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_r5", rdata1, 32'd0);
    chk("async_rst_cnt", wbCount, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // ALU writeback, then readback with write disabled
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7, 5'd0, 5'd7, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7, 5'd1, 1'b0);
    chk("alu_wb_count", wbCount, 32'd1);

    // Load writeback seen through both bypasses, then from storage
    step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h0000_0042, 5'd3, 5'd3, 5'd3, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd3, 1'b0);

    // r0 protection and disabled write
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 32'h0000_5555, 32'd0, 5'd9, 5'd0, 5'd9, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd7, 1'b0);

    // X data with the write disabled must leave storage alone
    Regfile_weW = 1'b0; aluOutW = 'x; readDataW = 'x; writeRegAddrW = 'x; memToRegW = 'x;
    @(posedge clk);
    @(negedge clk);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd3, 1'b0);

    // Randomized traffic, reads biased towards the write target
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wa;
      logic [4:0] r1;
      logic [4:0] r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           wa, r1, r2, ($urandom_range(0, 31) == 0));
    end

    // Counter wrap from a preloaded value near the top
    force dut.wb_count_q = 32'hFFFF_FFFD;
    #1 release dut.wb_count_q;
    mcnt = 32'hFFFF_FFFD;
    #1;
    chk("cnt_preload", wbCount, 32'hFFFF_FFFD);
    @(negedge clk);
    step(1'b1, 1'b0, 32'h0000_0001, 32'd0, 5'd1, 5'd1, 5'd2, 1'b0);
    chk("cnt_fffffffe", wbCount, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 32'h0000_0002, 32'd0, 5'd2, 5'd1, 5'd2, 1'b0);
    chk("cnt_ffffffff", wbCount, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'd0, 32'h0000_0003, 5'd4, 5'd4, 5'd2, 1'b0);
    chk("cnt_wrap", wbCount, 32'd0);
    step(1'b1, 1'b0, 32'h0000_0004, 32'd0, 5'd6, 5'd1, 5'd6, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0005, 32'd0, 5'd8, 5'd8, 5'd6, 1'b1);
    chk("clr_priority", wbCount, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd6, 1'b0);

    // A write on an edge that sees reset high is lost
    rst = 1'b1;
    Regfile_weW = 1'b1; memToRegW = 1'b0; aluOutW = 32'h0BAD_F00D; writeRegAddrW = 5'd10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd8, 1'b0);
    step(1'b1, 1'b0, 32'h0000_00AB, 32'd0, 5'd10, 5'd10, 5'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd10, 5'd10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
